// File: rtl/zint_ack_pkg.sv
// ---------------------------------------------------------------------------
// zint_ack_pkg
//   Shared definitions for the Z80 interrupt-acknowledge sequencer:
//   sequencer state encoding, opcode constants used by RETI detection,
//   the idle value of the vector latch and a small state-decode helper.
// ---------------------------------------------------------------------------
package zint_ack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_QUAL  = 3'd1,
    ST_ACK   = 3'd2,
    ST_LATCH = 3'd3,
    ST_DRIVE = 3'd4,
    ST_TAIL  = 3'd5
  } state_e;

  localparam logic [7:0] OPC_ED   = 8'hED;
  localparam logic [7:0] OPC_RETI = 8'h4D;
  localparam logic [7:0] DEF_VECT = 8'hFF;

  localparam int CNT_W = 4;

  // States in which an INTA is being serviced and intack is held high.
  function automatic logic is_ack_state(input state_e s);
    return (s == ST_ACK) || (s == ST_LATCH) || (s == ST_DRIVE) || (s == ST_TAIL);
  endfunction

endpackage

// File: rtl/zint_ack_sync.sv
// ---------------------------------------------------------------------------
// z80_sig_sync
//   Resynchronises one asynchronous Z80 bus pin into the clk domain.
//   Parameters: STAGES  - flop depth (>= 2)
//               RST_VAL - value all stages take on reset (1 = pin inactive)
//   Ports:      clk - system clock
//               res - synchronous active-high reset
//               d   - asynchronous pin
//               q   - synchronised pin, STAGES clks behind d
// ---------------------------------------------------------------------------
module z80_sig_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic res,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours; blocking here would
  // collapse the chain into a single stage in simulation.
  always_ff @(posedge clk) begin
    if (res) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/zint_ack.sv
// ---------------------------------------------------------------------------
// zint_ack
//   Z80 IM2 interrupt-acknowledge sequencer between the Z80 bus pins and zint.
//   Qualifies the INTA cycle (/M1 and /IORQ low together for ACK_MIN_CLKS
//   clks after resync), raises intack so zint re-selects its source, latches
//   im2vect one clk later and drives it onto the data bus until /IORQ rises.
//
//   Parameters: SYNC_STAGES  - resync depth on every async input (>= 2)
//               ACK_MIN_CLKS - clks m1&iorq must be low to qualify (1..15)
//   Build option: define RETI_DETECT_EN to enable RETI (ED 4D) fetch
//                 detection; otherwise reti is tied low and mreq_n, rd_n,
//                 din are unused.
//
//   Ports: clk     in   system clock
//          res     in   synchronous active-high reset
//          m1_n    in   Z80 /M1 (async)
//          iorq_n  in   Z80 /IORQ (async)
//          mreq_n  in   Z80 /MREQ (async, RETI detection only)
//          rd_n    in   Z80 /RD (async, RETI detection only)
//          din     in   Z80 data bus (RETI detection only)
//          im2vect in   vector from zint
//          intack  out  INTA in progress, level, to zint
//          vect_oe out  data bus output enable for dout
//          dout    out  latched IM2 vector (held between acks)
//          reti    out  one-clk pulse on RETI fetch
// ---------------------------------------------------------------------------
module zint_ack
  import zint_ack_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int ACK_MIN_CLKS = 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic       mreq_n,
  input  logic       rd_n,
  input  logic [7:0] din,
  input  logic [7:0] im2vect,
  output logic       intack,
  output logic       vect_oe,
  output logic [7:0] dout,
  output logic       reti
);

  localparam logic [CNT_W-1:0] ACK_MIN = CNT_W'(ACK_MIN_CLKS);

  // -------------------------------------------------------------------------
  // Input resync
  // -------------------------------------------------------------------------
  logic m1_s;
  logic iorq_s;

  z80_sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_m1 (
    .clk (clk), .res (res), .d (m1_n), .q (m1_s)
  );

  z80_sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_iorq (
    .clk (clk), .res (res), .d (iorq_n), .q (iorq_s)
  );

  logic ack_lo;
  assign ack_lo = !m1_s && !iorq_s;

  // -------------------------------------------------------------------------
  // Sequencer state
  // -------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               intack_q, intack_d;
  logic               vect_oe_q, vect_oe_d;
  logic [7:0]         dout_q, dout_d;

  // After a reset the INTA in flight must not be picked up again. block_q
  // holds off qualification until m1_s is genuinely seen high; settle_q
  // masks the SYNC_STAGES clks where the resync chain still shows its reset
  // value instead of the real pin.
  logic                   block_q, block_d;
  logic [SYNC_STAGES-1:0] settle_q, settle_d;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      intack_q  <= 1'b0;
      vect_oe_q <= 1'b0;
      dout_q    <= DEF_VECT;
      block_q   <= 1'b1;
      settle_q  <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      intack_q  <= intack_d;
      vect_oe_q <= vect_oe_d;
      dout_q    <= dout_d;
      block_q   <= block_d;
      settle_q  <= settle_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal written in a combinational block gets a default at
  // the top so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    logic [CNT_W-1:0] cnt_inc;
    state_d  = state_q;
    cnt_d    = '0;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    settle_d = {settle_q[SYNC_STAGES-2:0], 1'b0};
    block_d  = block_q && !((settle_q == '0) && m1_s);

    case (state_q)
      ST_IDLE: begin
        if (ack_lo && !block_q) begin
          if (ACK_MIN_CLKS == 1) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_QUAL;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_QUAL: begin
        if (!ack_lo) begin
          state_d = ST_IDLE;            // glitch rejected
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= ACK_MIN) state_d = ST_ACK;
        end
      end
      // ACK lasts exactly one clk so zint can re-latch its source select.
      ST_ACK: begin
        if (m1_s)        state_d = ST_IDLE;
        else if (iorq_s) state_d = ST_TAIL;
        else             state_d = ST_LATCH;
      end
      ST_LATCH: begin
        state_d = m1_s ? ST_IDLE : ST_DRIVE;
      end
      ST_DRIVE: begin
        if (m1_s)        state_d = ST_IDLE;
        else if (iorq_s) state_d = ST_TAIL;
      end
      ST_TAIL: begin
        if (m1_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: outputs are registered from the next state so they are
  // glitch-free at the pins; vect_oe is only ever set in a state that also
  // sets intack.
  always_comb begin
    intack_d  = is_ack_state(state_d);
    vect_oe_d = (state_d == ST_DRIVE);
    dout_d    = (state_q == ST_LATCH) ? im2vect : dout_q;
  end

  assign intack  = intack_q;
  assign vect_oe = vect_oe_q;
  assign dout    = dout_q;

  // -------------------------------------------------------------------------
  // RETI detection
  // -------------------------------------------------------------------------
`ifdef RETI_DETECT_EN
  logic mreq_s;
  logic rd_s;

  z80_sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mreq (
    .clk (clk), .res (res), .d (mreq_n), .q (mreq_s)
  );

  z80_sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
    .clk (clk), .res (res), .d (rd_n), .q (rd_s)
  );

  logic fetch;
  logic capture;
  logic fetch_act_q, fetch_act_d;
  logic ed_seen_q, ed_seen_d;
  logic reti_q, reti_d;

  assign fetch = !m1_s && !mreq_s && !rd_s;

  // fetch_act_q remembers an opcode fetch until /RD rises, so the byte is
  // still captured if /M1 happens to resync high on the same clk as /RD.
  assign capture = fetch_act_q && rd_s;

  always_comb begin
    fetch_act_d = fetch || (fetch_act_q && !rd_s);
    ed_seen_d   = ed_seen_q;
    reti_d      = 1'b0;
    if (capture) begin
      if (din == OPC_ED) begin
        ed_seen_d = 1'b1;
      end else begin
        // Any other byte, prefixes DD/FD included, breaks the ED 4D pair.
        reti_d    = (din == OPC_RETI) && ed_seen_q;
        ed_seen_d = 1'b0;
      end
    end
    if (state_q == ST_ACK) ed_seen_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      fetch_act_q <= 1'b0;
      ed_seen_q   <= 1'b0;
      reti_q      <= 1'b0;
    end else begin
      fetch_act_q <= fetch_act_d;
      ed_seen_q   <= ed_seen_d;
      reti_q      <= reti_d;
    end
  end

  assign reti = reti_q;
`else
  logic unused_reti_pins;
  assign unused_reti_pins = ^{mreq_n, rd_n, din};
  assign reti = 1'b0;
`endif

endmodule

// File: tb/tb_zint_ack.sv
module tb_zint_ack;

  logic       clk = 1'b0;
  logic       res;
  logic       m1_n, iorq_n, mreq_n, rd_n;
  logic [7:0] din, im2vect;
  logic       intack, vect_oe, reti;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zint_ack dut (
    .clk     (clk),
    .res     (res),
    .m1_n    (m1_n),
    .iorq_n  (iorq_n),
    .mreq_n  (mreq_n),
    .rd_n    (rd_n),
    .din     (din),
    .im2vect (im2vect),
    .intack  (intack),
    .vect_oe (vect_oe),
    .dout    (dout),
    .reti    (reti)
  );

  typedef struct {
    logic       m1_n;
    logic       iorq_n;
    logic [7:0] vect;
    logic       intack;
    logic       vect_oe;
    logic [7:0] dout;
  } vec_t;

  typedef struct {
    logic       intack;
    logic       vect_oe;
    logic [7:0] dout;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic m, input logic i, input logic [7:0] v,
                     input logic ia, input logic oe, input logic [7:0] d);
    vec_t r;
    r.m1_n = m; r.iorq_n = i; r.vect = v;
    r.intack = ia; r.vect_oe = oe; r.dout = d;
    vecs.push_back(r);
  endtask

  // One opcode fetch cycle; counts clks on which reti is high.
  task automatic fetch_op(input logic [7:0] op, output int pulses);
    pulses = 0;
    m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; din = op;
    repeat (3) begin tick(); pulses += int'(reti); end
    m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1;
    repeat (6) begin tick(); pulses += int'(reti); end
    din = 8'h00;
  endtask

  initial begin
    int   pulses;
    int   exp_reti;
    exp_t e;

    res = 1'b1; m1_n = 1'b1; iorq_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1;
    din = 8'h00; im2vect = 8'hFD;

    // Stimulus table: each row is driven for one clk; expectations are the
    // outputs seen just after the following edge.
    // Full INTA with im2vect FD, then IORQ release, then M1 release.
    repeat (3) add(0, 0, 8'hFD, 0, 0, 8'hFF);
    repeat (2) add(0, 0, 8'hFD, 1, 0, 8'hFF);
    repeat (5) add(0, 0, 8'hFD, 1, 1, 8'hFD);
    repeat (2) add(0, 1, 8'hFD, 1, 1, 8'hFD);
    add(0, 1, 8'hFD, 1, 0, 8'hFD);
    repeat (2) add(1, 1, 8'hFD, 1, 0, 8'hFD);
    repeat (2) add(1, 1, 8'hFD, 0, 0, 8'hFD);
    // Vector changes from FF to FB while in LATCH; M1 and IORQ rise together
    // while driving.
    repeat (3) add(0, 0, 8'hFF, 0, 0, 8'hFD);
    repeat (2) add(0, 0, 8'hFF, 1, 0, 8'hFD);
    repeat (2) add(0, 0, 8'hFB, 1, 1, 8'hFB);
    repeat (2) add(1, 1, 8'hFB, 1, 1, 8'hFB);
    repeat (2) add(1, 1, 8'hFB, 0, 0, 8'hFB);

    // Reset state.
    repeat (3) tick();
    check("reset intack", intack, 0);
    check("reset vect_oe", vect_oe, 0);
    check("reset dout", dout, 8'hFF);
    check("reset reti", reti, 0);
    res = 1'b0;
    repeat (5) tick();

    foreach (vecs[i]) begin
      m1_n = vecs[i].m1_n; iorq_n = vecs[i].iorq_n; im2vect = vecs[i].vect;
      sb.push_back('{vecs[i].intack, vecs[i].vect_oe, vecs[i].dout});
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d intack", i), intack, e.intack);
      check($sformatf("vec%0d vect_oe", i), vect_oe, e.vect_oe);
      check($sformatf("vec%0d dout", i), dout, e.dout);
    end

    // One-clk IORQ glitch is rejected; a following real IORQ qualifies with
    // the full latency, showing the sequencer went back to IDLE.
    im2vect = 8'hA5;
    m1_n = 1'b0; iorq_n = 1'b0;
    tick();
    iorq_n = 1'b1;
    for (int k = 0; k < 6; k++) begin tick(); check($sformatf("glitch intack %0d", k), intack, 0); end
    iorq_n = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); check($sformatf("post-glitch lat %0d", k), intack, 0); end
    tick();
    check("post-glitch intack", intack, 1);
    repeat (3) tick();
    check("post-glitch dout", dout, 8'hA5);
    m1_n = 1'b1; iorq_n = 1'b1;
    repeat (4) tick();
    check("post-glitch release", intack, 0);

    // Reset while driving: everything drops and the held-low INTA is not
    // re-acknowledged until M1 has gone high.
    im2vect = 8'hFD;
    m1_n = 1'b0; iorq_n = 1'b0;
    repeat (6) tick();
    check("pre-reset vect_oe", vect_oe, 1);
    res = 1'b1;
    tick();
    res = 1'b0;
    check("mid-reset intack", intack, 0);
    check("mid-reset vect_oe", vect_oe, 0);
    check("mid-reset dout", dout, 8'hFF);
    for (int k = 0; k < 10; k++) begin tick(); check($sformatf("no re-ack %0d", k), intack, 0); end
    m1_n = 1'b1; iorq_n = 1'b1;
    repeat (6) tick();
    m1_n = 1'b0; iorq_n = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); check($sformatf("re-arm lat %0d", k), intack, 0); end
    tick();
    check("re-arm intack", intack, 1);
    repeat (3) tick();
    check("re-arm dout", dout, 8'hFD);
    m1_n = 1'b1; iorq_n = 1'b1;
    repeat (4) tick();

    // IORQ rises during ACK: straight to TAIL, no bus drive, intack held
    // until M1 rises.
    m1_n = 1'b0; iorq_n = 1'b0; im2vect = 8'h12;
    repeat (2) tick();
    iorq_n = 1'b1;
    tick();
    check("ack-iorq pre intack", intack, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("ack-iorq intack %0d", k), intack, 1);
      check($sformatf("ack-iorq vect_oe %0d", k), vect_oe, 0);
    end
    m1_n = 1'b1;
    repeat (2) begin tick(); check("ack-iorq tail intack", intack, 1); end
    tick();
    check("ack-iorq release", intack, 0);
    check("ack-iorq dout held", dout, 8'hFD);

    // RETI detection (expected pulses depend on the build option).
`ifdef RETI_DETECT_EN
    exp_reti = 1;
`else
    exp_reti = 0;
`endif
    fetch_op(8'hED, pulses); check("reti ED", pulses[7:0], 0);
    fetch_op(8'h4D, pulses); check("reti ED 4D", pulses[7:0], exp_reti[7:0]);
    fetch_op(8'hED, pulses); check("reti2 ED", pulses[7:0], 0);
    fetch_op(8'h00, pulses); check("reti2 00", pulses[7:0], 0);
    fetch_op(8'h4D, pulses); check("reti2 4D", pulses[7:0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
